comparar_parejas: RTL and testbench

// - Stage downstream of card selection in the memory game. After the player has two face-up cards
//   (state 01), it scans the 16-card array, finds both, and compares their symbols.
// - Match: both cards become matched (10) and the pair score increments.
// - Mismatch: both are held face-up for a display delay, then returned to hidden (00).
// - Its result array feeds the next selection round and the display.

---
 rtl/comparar_parejas_if.sv | 22 ++
 rtl/comparar_parejas.sv | 131 +++++++++++++
 tb/tb_comparar_parejas.sv | 136 +++++++++++++
 3 files changed

// File: rtl/comparar_parejas_if.sv
// comparar_parejas_if: pair-compare bus; master drives start/clear_score/arr_in, slave returns arr_out/done/match/error/pairs_found/all_found
interface comparar_parejas_if #(
  parameter int N_CARDS = 16
);
  logic                    start;
  logic                    clear_score;
  logic [N_CARDS-1:0][4:0] arr_in;
  logic [N_CARDS-1:0][4:0] arr_out;
  logic                    done;
  logic                    match;
  logic                    error;
  logic [3:0]              pairs_found;
  logic                    all_found;
  modport master (
    output start, clear_score, arr_in,
    input  arr_out, done, match, error, pairs_found, all_found
  );
  modport slave (
    input  start, clear_score, arr_in,
    output arr_out, done, match, error, pairs_found, all_found
  );
endinterface

// File: rtl/comparar_parejas.sv
// comparar_parejas: scans the card array (bus.arr_in) for the two face-up cards, compares their symbols, marks matched/hidden into bus.arr_out with a done/match/error pulse and pair score; clk, async active-low rst; MISMATCH_HOLD_EN adds a HOLD_CYCLES face-up hold on mismatch
module comparar_parejas #(
  parameter int N_CARDS     = 16,
  parameter int HOLD_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  comparar_parejas_if.slave bus
);
  localparam int IW = $clog2(N_CARDS);
`ifdef MISMATCH_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SCAN, COMPARE, HOLD, WRITE} state_t;
  logic [HW-1:0] hold_q, hold_d;
`else
  typedef enum logic [2:0] {IDLE, SCAN, COMPARE, WRITE} state_t;
`endif
  state_t                  state_q, state_d;
  logic [N_CARDS-1:0][4:0] arr_q, arr_d;
  logic [IW-1:0]           idx_q, idx_d, idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    res_match_q, res_match_d, res_err_q, res_err_d;
  logic                    done_q, done_d, match_q, match_d, error_q, error_d;
  logic [3:0]              pairs_q, pairs_d;
  logic                    same_sym;
  assign same_sym = arr_q[idx_a_q][4:2] == arr_q[idx_b_q][4:2];
  always_comb begin
    state_d     = state_q;
    arr_d       = arr_q;
    idx_d       = idx_q;
    idx_a_d     = idx_a_q;
    idx_b_d     = idx_b_q;
    cnt_d       = cnt_q;
    res_match_d = res_match_q;
    res_err_d   = res_err_q;
    pairs_d     = pairs_q;
    done_d      = 1'b0;
    match_d     = 1'b0;
    error_d     = 1'b0;
`ifdef MISMATCH_HOLD_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.clear_score) pairs_d = '0;
        if (bus.start) begin
          arr_d   = bus.arr_in;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (arr_q[idx_q][1:0] == 2'b01) begin
          idx_a_d = (cnt_q == 2'd0) ? idx_q : idx_a_q;
          idx_b_d = (cnt_q == 2'd1) ? idx_q : idx_b_q;
          cnt_d   = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
        end
        idx_d   = IW'(idx_q + 1'b1);
        state_d = (idx_q == IW'(N_CARDS - 1)) ? COMPARE : SCAN;
      end
      COMPARE: begin
        res_err_d   = cnt_q != 2'd2;
        res_match_d = cnt_q == 2'd2 && same_sym;
`ifdef MISMATCH_HOLD_EN
        hold_d      = '0;
        state_d     = (cnt_q == 2'd2 && !same_sym) ? HOLD : WRITE;
      end
      HOLD: begin
        hold_d  = HW'(hold_q + 1'b1);
        state_d = (hold_q == HW'(HOLD_CYCLES - 1)) ? WRITE : HOLD;
`else
        state_d     = WRITE;
`endif
      end
      WRITE: begin
        done_d  = 1'b1;
        match_d = res_match_q;
        error_d = res_err_q;
        if (!res_err_q) begin
          arr_d[idx_a_q][1:0] = res_match_q ? 2'b10 : 2'b00;
          arr_d[idx_b_q][1:0] = res_match_q ? 2'b10 : 2'b00;
        end
        if (res_match_q && pairs_q != 4'(N_CARDS / 2)) pairs_d = pairs_q + 4'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      arr_q       <= '0;
      idx_q       <= '0;
      idx_a_q     <= '0;
      idx_b_q     <= '0;
      cnt_q       <= '0;
      res_match_q <= 1'b0;
      res_err_q   <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      error_q     <= 1'b0;
      pairs_q     <= '0;
`ifdef MISMATCH_HOLD_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      arr_q       <= arr_d;
      idx_q       <= idx_d;
      idx_a_q     <= idx_a_d;
      idx_b_q     <= idx_b_d;
      cnt_q       <= cnt_d;
      res_match_q <= res_match_d;
      res_err_q   <= res_err_d;
      done_q      <= done_d;
      match_q     <= match_d;
      error_q     <= error_d;
      pairs_q     <= pairs_d;
`ifdef MISMATCH_HOLD_EN
      hold_q      <= hold_d;
`endif
    end
  end
  assign bus.arr_out     = arr_q;
  assign bus.done        = done_q;
  assign bus.match       = match_q;
  assign bus.error       = error_q;
  assign bus.pairs_found = pairs_q;
  assign bus.all_found   = pairs_q == 4'(N_CARDS / 2);
endmodule

// File: tb/tb_comparar_parejas.sv
// tb_comparar_parejas: directed self-checking bench for comparar_parejas
module tb_comparar_parejas;
  localparam int N = 16;
`ifdef MISMATCH_HOLD_EN
  localparam int HL = 4;
`else
  localparam int HL = 0;
`endif
  typedef logic [N-1:0][4:0] arr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  comparar_parejas_if #(.N_CARDS(N)) bus ();
  comparar_parejas #(.N_CARDS(N), .HOLD_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_chk = 0;
  int n_fail = 0;
  int lat, nd;
  logic gm, ge, post;
  arr_t ga, snap, a, e;
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input arr_t ai, input logic clr, input logic spam);
    bus.arr_in = ai;
    bus.clear_score = clr;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.clear_score = 1'b0;
    lat = -1;
    nd = 0;
    post = 1'bx;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.start = spam && k == 4;
      if (k == N + 1 + HL) snap = bus.arr_out;
      if (lat >= 0 && k == lat + 1) post = bus.match | bus.error;
      if (bus.done) begin
        nd++;
        if (lat < 0) begin
          lat = k;
          gm = bus.match;
          ge = bus.error;
          ga = bus.arr_out;
        end
      end
    end
  endtask
  task automatic op_chk(input string tag, input int elat, input logic em, input logic ee,
                        input arr_t ea, input logic [3:0] ep);
    chk({tag, "_latency"}, 80'(lat), 80'(elat));
    chk({tag, "_done_count"}, 80'(nd), 80'd1);
    chk({tag, "_match"}, 80'(gm), 80'(em));
    chk({tag, "_error"}, 80'(ge), 80'(ee));
    chk({tag, "_arr_out"}, ga, ea);
    chk({tag, "_flags_cleared"}, 80'(post), 80'd0);
    chk({tag, "_pairs"}, 80'(bus.pairs_found), 80'(ep));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.clear_score = 1'b0;
    bus.arr_in = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 80'(bus.done), 80'd0);
    chk("rst_match", 80'(bus.match), 80'd0);
    chk("rst_error", 80'(bus.error), 80'd0);
    chk("rst_pairs", 80'(bus.pairs_found), 80'd0);
    chk("rst_all", 80'(bus.all_found), 80'd0);
    chk("rst_arr", bus.arr_out, 80'd0);
    rst = 1'b1;
    @(negedge clk);
    a = '0; a[2] = 5'b011_01; a[9] = 5'b011_01; a[3] = 5'b111_11; a[4] = 5'b010_10;
    e = a; e[2] = 5'b011_10; e[9] = 5'b011_10;
    do_op(a, 1'b0, 1'b0);
    op_chk("match", N + 2, 1'b1, 1'b0, e, 4'd1);
    a = '0; a[0] = 5'b001_01; a[15] = 5'b110_01; a[7] = 5'b110_11;
    e = a; e[0] = 5'b001_00; e[15] = 5'b110_00;
    do_op(a, 1'b0, 1'b0);
    chk("mismatch_visible", snap, a);
    op_chk("mismatch", N + 2 + HL, 1'b0, 1'b0, e, 4'd1);
    a = '0; a[5] = 5'b101_01; a[6] = 5'b101_10;
    do_op(a, 1'b0, 1'b0);
    op_chk("err_one", N + 2, 1'b0, 1'b1, a, 4'd1);
    a = '0; a[1] = 5'b010_01; a[4] = 5'b010_01; a[7] = 5'b010_01; a[8] = 5'b001_11;
    do_op(a, 1'b0, 1'b0);
    op_chk("err_three", N + 2, 1'b0, 1'b1, a, 4'd1);
    for (int i = 1; i < 8; i++) begin
      a = '0; a[i] = {3'(i), 2'b01}; a[i + 8] = {3'(i), 2'b01};
      e = a; e[i] = {3'(i), 2'b10}; e[i + 8] = {3'(i), 2'b10};
      do_op(a, 1'b0, 1'b0);
      op_chk("fill", N + 2, 1'b1, 1'b0, e, 4'(i + 1));
    end
    chk("full_all_found", 80'(bus.all_found), 80'd1);
    a = '0; a[0] = 5'b000_01; a[8] = 5'b000_01;
    e = a; e[0] = 5'b000_10; e[8] = 5'b000_10;
    do_op(a, 1'b0, 1'b0);
    op_chk("ninth", N + 2, 1'b1, 1'b0, e, 4'd8);
    chk("ninth_all_found", 80'(bus.all_found), 80'd1);
    bus.clear_score = 1'b1;
    @(negedge clk);
    bus.clear_score = 1'b0;
    chk("clear_pairs", 80'(bus.pairs_found), 80'd0);
    chk("clear_all", 80'(bus.all_found), 80'd0);
    do_op(a, 1'b1, 1'b0);
    op_chk("clear_and_start", N + 2, 1'b1, 1'b0, e, 4'd1);
    a = '0; a[10] = 5'b100_01; a[12] = 5'b100_01;
    e = a; e[10] = 5'b100_10; e[12] = 5'b100_10;
    do_op(a, 1'b0, 1'b1);
    op_chk("start_in_scan", N + 2, 1'b1, 1'b0, e, 4'd2);
    a = '0; a[0] = 5'b001_01; a[15] = 5'b110_01;
    bus.arr_in = a;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (N + 2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_done", 80'(bus.done), 80'd0);
    chk("midrst_arr", bus.arr_out, 80'd0);
    chk("midrst_pairs", 80'(bus.pairs_found), 80'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a = '0; a[3] = 5'b110_01; a[14] = 5'b110_01;
    e = a; e[3] = 5'b110_10; e[14] = 5'b110_10;
    do_op(a, 1'b0, 1'b0);
    op_chk("after_rst", N + 2, 1'b1, 1'b0, e, 4'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
